// File: rtl/nway_cache_controller.sv
// nway_cache_controller: N-way set-associative write-back/write-allocate cache controller
// with true-LRU age counters per set and saturating hit/miss statistics.
module nway_cache_controller #(
  parameter int WAYS    = 4,
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 10,
  parameter int DATA_W  = 128,
  localparam int ADDR_W = TAG_W + INDEX_W,
  localparam int AGE_W  = $clog2(WAYS),
  localparam int SETS   = 1 << INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpu_valid,
  input  logic              i_cpu_rw,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ready,
  output logic              o_mem_valid,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic [31:0]       o_hit_count,
  output logic [31:0]       o_miss_count
);
  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;
  typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;
  function automatic ages_t age_init();
    for (int w = 0; w < WAYS; w++) age_init[w] = AGE_W'(w);
  endfunction
  state_t                         r_state;
  logic [SETS-1:0][WAYS-1:0]      r_valid;
  logic [SETS-1:0][WAYS-1:0]      r_dirty;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] r_age;
  logic [TAG_W-1:0]               r_tag  [SETS][WAYS];
  logic [DATA_W-1:0]              r_data [SETS][WAYS];
  logic [AGE_W-1:0]               r_victim;
  logic                           r_fill;
  logic [TAG_W-1:0]               w_tag;
  logic [INDEX_W-1:0]             w_idx;
  logic                           w_hit;
  logic                           w_has_inv;
  logic [AGE_W-1:0]               w_hit_way;
  logic [AGE_W-1:0]               w_inv_way;
  logic [AGE_W-1:0]               w_old_way;
  logic [AGE_W-1:0]               w_victim;
  assign w_tag = i_cpu_addr[ADDR_W-1:INDEX_W];
  assign w_idx = i_cpu_addr[INDEX_W-1:0];
  // Downward scan so the lowest-index invalid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    w_old_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = AGE_W'(w);
      end
      if (r_age[w_idx][w] == AGE_W'(WAYS - 1)) w_old_way = AGE_W'(w);
    end
    w_victim = w_has_inv ? w_inv_way : w_old_way;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_age        <= {SETS{age_init()}};
      r_victim     <= '0;
      r_fill       <= 1'b0;
      o_cpu_ready  <= 1'b0;
      o_cpu_rdata  <= '0;
      o_mem_valid  <= 1'b0;
      o_mem_rw     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_hit_count  <= '0;
      o_miss_count <= '0;
    end else begin
      o_cpu_ready <= 1'b0;
      case (r_state)
        IDLE: if (i_cpu_valid) r_state <= COMPARE;
        COMPARE: begin
          r_fill <= 1'b0;
          if (w_hit) begin
            o_cpu_ready <= 1'b1;
            r_state     <= IDLE;
            if (i_cpu_rw) begin
              r_data[w_idx][w_hit_way]  <= i_cpu_wdata;
              r_dirty[w_idx][w_hit_way] <= 1'b1;
            end else o_cpu_rdata <= r_data[w_idx][w_hit_way];
            for (int w = 0; w < WAYS; w++)
              if (r_age[w_idx][w] < r_age[w_idx][w_hit_way]) r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
            r_age[w_idx][w_hit_way] <= '0;
            if (!r_fill && ~&o_hit_count) o_hit_count <= o_hit_count + 1'b1;
          end else begin
            r_victim    <= w_victim;
            o_mem_valid <= 1'b1;
            if (~&o_miss_count) o_miss_count <= o_miss_count + 1'b1;
            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
              r_state     <= WRITE_BACK;
              o_mem_rw    <= 1'b1;
              o_mem_addr  <= {r_tag[w_idx][w_victim], w_idx};
              o_mem_wdata <= r_data[w_idx][w_victim];
            end else begin
              r_state    <= ALLOCATE;
              o_mem_rw   <= 1'b0;
              o_mem_addr <= i_cpu_addr;
            end
          end
        end
        WRITE_BACK: if (i_mem_ready) begin
          r_dirty[w_idx][r_victim] <= 1'b0;
          r_state                  <= ALLOCATE;
          o_mem_rw                 <= 1'b0;
          o_mem_addr               <= i_cpu_addr;
        end
        ALLOCATE: if (i_mem_ready) begin
          r_data[w_idx][r_victim]  <= i_mem_rdata;
          r_tag[w_idx][r_victim]   <= w_tag;
          r_valid[w_idx][r_victim] <= 1'b1;
          r_dirty[w_idx][r_victim] <= 1'b0;
          o_mem_valid              <= 1'b0;
          r_fill                   <= 1'b1;
          r_state                  <= COMPARE;
        end
      endcase
    end
  end
endmodule
